// File: rtl/mem_if_pkg.sv
// Shared constants and FSM state type for the MAR/MDR-to-RAM sequencing bridge.
// MEM_IF_PROT_EN (in mem_interface) enables low-address store protection.
package mem_if_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;

    // First writable word address when store protection is compiled in
    localparam logic [ADDR_W-1:0] DEF_PROT_LIMIT = ADDR_W'(16);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD     = 3'd2,
        RD_CAP = 3'd3,
        DONE   = 3'd4
    } mem_if_state_t;

endpackage

// File: rtl/mem_if_prot_chk.sv
// Store-protection comparator: flags word addresses below the writable limit.
// Only instantiated when MEM_IF_PROT_EN is defined.
module mem_if_prot_chk
    import mem_if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LIMIT = DEF_PROT_LIMIT
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              below_c_o
);

    assign below_c_o = (addr_i < LIMIT);

endmodule

// File: rtl/mem_interface.sv
// Single-request load/store sequencer between MAR/MDR and a synchronous-read RAM.
// Define MEM_IF_PROT_EN to block stores below PROT_LIMIT and report them on err.
module mem_interface
    import mem_if_pkg::*;
`ifdef MEM_IF_PROT_EN
#(
    parameter logic [ADDR_W-1:0] PROT_LIMIT = DEF_PROT_LIMIT
)
`endif
(
    input  logic              clock,
    input  logic              clear_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    mem_if_state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic ram_read_q, ram_read_d;
    logic ram_write_q, ram_write_d;

    logic accept_c;
    logic blocked_c;

    // A request is only ever sampled while idle; everything else ignores req
    assign accept_c = (state_q == IDLE) && req;

    assign addr_d  = accept_c ? addr  : addr_q;
    assign wdata_d = accept_c ? wdata : wdata_q;
    assign we_d    = accept_c ? we    : we_q;

`ifdef MEM_IF_PROT_EN
    logic err_q, err_d;

    // Compared on the value addr_q will hold, so the write strobe can be registered
    mem_if_prot_chk #(
        .LIMIT     (PROT_LIMIT)
    ) u_prot_chk (
        .addr_i    (addr_d),
        .below_c_o (blocked_c)
    );
`else
    assign blocked_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = we ? WR : RD;
                end
            end
            WR:      state_d = DONE;
            RD:      state_d = RD_CAP;
            RD_CAP:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and capture logic; strobes are registered from the state being entered
    always_comb begin
        rdata_d     = rdata_q;
        busy_d      = 1'b0;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        done_d      = 1'b0;

        if (state_q == RD_CAP) begin
            rdata_d = ram_data_out;
        end

        busy_d      = (state_d != IDLE);
        ram_read_d  = (state_d == RD) && !we_d;
        ram_write_d = (state_d == WR) && we_d && !blocked_c;
        done_d      = (state_q == DONE);
    end

`ifdef MEM_IF_PROT_EN
    // Outside IDLE addr_d equals addr_q, so the comparator reflects the latched store
    always_comb begin
        err_d = 1'b0;
        err_d = (state_q == DONE) && we_q && blocked_c;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Request latches, load result and registered strobes
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
        end
    end

    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: random loads/stores against a word-array model.
// Honours MEM_IF_PROT_EN when expecting blocked stores.
module tb_mem_interface;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned PLIM  = 16;
`ifdef MEM_IF_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    always #5 clock = ~clock;

    mem_interface dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Synchronous-read RAM: address registered on a read edge, data visible next cycle
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_areg;
    always @(posedge clock) begin
        if (ram_write) ram[ram_address] = ram_data_in;
        if (ram_read)  ram_areg <= ram_address;
    end
    assign ram_data_out = ram[ram_areg];

    // Reference model: plain word array plus the last completed load value
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rdata;

    typedef struct {
        bit            is_load;
        logic [DW-1:0] rdata;
        bit            err;
        int            wr_cnt;
        int            rd_cnt;
        longint        cyc;
    } exp_t;

    exp_t   sb [$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     wr_seen = 0;
    int     rd_seen = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clock) begin
        exp_t e;
        if (!clear_n) begin
            wr_seen = 0;
            rd_seen = 0;
        end else begin
            chk("rw_exclusive", 64'(ram_read & ram_write), 64'd0);
            if (ram_write) wr_seen++;
            if (ram_read)  rd_seen++;
            if (err && !done) chk("err_without_done", 64'(err), 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rdata",      64'(rdata), 64'(e.rdata));
                    chk("err",        64'(err), 64'(e.err));
                    chk("write_count", 64'(wr_seen), 64'(e.wr_cnt));
                    chk("read_count",  64'(rd_seen), 64'(e.rd_cnt));
                end
                wr_seen = 0;
                rd_seen = 0;
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Expected outcome from the rules: loads return the array word, stores below the limit are dropped
    task automatic push_expect(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        bit   blk;
        blk = PROT && (int'(a) < int'(PLIM));
        e.is_load = !w;
        if (w) begin
            if (!blk) ref_mem[a] = d;
        end else begin
            ref_rdata = ref_mem[a];
        end
        e.rdata  = ref_rdata;
        e.err    = w && blk;
        e.wr_cnt = (w && !blk) ? 1 : 0;
        e.rd_cnt = w ? 0 : 1;
        e.cyc    = cyc + 1 + (w ? 2 : 3);
        sb.push_back(e);
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle();
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        push_expect(w, a, d);
        @(posedge clock);
        #1;
        req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_ram_read"}, 64'(ram_read), 64'd0);
        chk({tag, "_ram_write"}, 64'(ram_write), 64'd0);
        chk({tag, "_ram_address"}, 64'(ram_address), 64'd0);
        chk({tag, "_ram_data_in"}, 64'(ram_data_in), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            w;

        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]     = DW'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
            ref_mem[i] = DW'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
        end
        ram[9'h095]     = 32'h0000_0022;
        ref_mem[9'h095] = 32'h0000_0022;
        ref_rdata = '0;

        clear_n = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        #12;
        check_all_zero("reset");
        #10;
        clear_n = 1'b1;

        // Directed: store/load round trips and the preloaded word
        issue(1'b1, 9'h087, 32'hDEADBEEF);
        issue(1'b0, 9'h087, 32'h0);
        issue(1'b0, 9'h095, 32'h0);

        // Protection boundary: below, just below and at the limit
        issue(1'b1, 9'h004, 32'h12345678);
        issue(1'b0, 9'h004, 32'h0);
        issue(1'b1, AW'(PLIM - 1), 32'hCAFEF00D);
        issue(1'b0, AW'(PLIM - 1), 32'h0);
        issue(1'b1, AW'(PLIM), 32'hA5A5_5A5A);
        issue(1'b0, AW'(PLIM), 32'h0);

        // Random back-to-back traffic, biased toward the protected region
        for (int n = 0; n < 80; n++) begin
            w = 1'(($urandom_range(0, 1)));
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 23)) : AW'($urandom_range(0, 511));
            d = DW'($urandom);
            issue(w, a, d);
        end

        // Requests during RD_CAP and DONE must be ignored
        wait_idle();
        req = 1'b1; we = 1'b0; addr = 9'h087; wdata = '0;
        push_expect(1'b0, 9'h087, '0);
        @(posedge clock); #1;
        req = 1'b0;
        chk("load_ram_read", 64'(ram_read), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        @(posedge clock); #1;
        req = 1'b1; we = 1'b0; addr = 9'h05A;
        @(posedge clock); #1;
        @(posedge clock); #1;
        req = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        chk("ignore_busy", 64'(busy), 64'd0);
        chk("ignore_rdata", 64'(rdata), 64'(ref_rdata));

        // Reset during WR: strobe drops at once and the RAM keeps its old word
        wait_idle();
        req = 1'b1; we = 1'b1; addr = 9'h100; wdata = 32'hBAD0_BAD0;
        @(posedge clock); #1;
        req = 1'b0;
        chk("midwr_ram_write", 64'(ram_write), 64'd1);
        clear_n = 1'b0;
        #1;
        check_all_zero("midwr_reset");
        ref_rdata = '0;
        repeat (2) @(negedge clock);
        #1;
        clear_n = 1'b1;
        issue(1'b0, 9'h100, 32'h0);
        issue(1'b1, 9'h087, 32'h0BAD_F00D);
        issue(1'b0, 9'h087, 32'h0);

        wait_idle();
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
